// File: rtl/rom_lector_pkg.sv
// Shared definitions for the ROM block reader.
// Holds the default geometry of the ROM behind the reader (address and
// data widths), its depth, and the encoding of the controller states.
package rom_pkg;

  localparam int AW_DEF = 3;
  localparam int DW_DEF = 4;
  localparam int PROF   = 1 << AW_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } estado_t;

endpackage

// File: rtl/rom_lector_if.sv
// Bundle of every non-clock signal of the ROM block reader.
//   inicio, dir_inicial, n_palabras : block request from software
//   address, datos                  : ROM address out, combinational ROM word in
//   dato_out, valido, listo         : valid/ready stream to the consumer
//   ocupado, fin                    : busy flag and end-of-block pulse
// The master modport is the reader; the slave modport is everything around it.
interface rom_lector_if #(
  parameter int AW = 3,
  parameter int DW = 4
);

  logic          inicio;
  logic [AW-1:0] dir_inicial;
  logic [AW:0]   n_palabras;
  logic [AW-1:0] address;
  logic [DW-1:0] datos;
  logic [DW-1:0] dato_out;
  logic          valido;
  logic          listo;
  logic          ocupado;
  logic          fin;

  modport master (
    input  inicio, dir_inicial, n_palabras, datos, listo,
    output address, dato_out, valido, ocupado, fin
  );

  modport slave (
    output inicio, dir_inicial, n_palabras, datos, listo,
    input  address, dato_out, valido, ocupado, fin
  );

endinterface

// File: rtl/rom_lector_contador_dir.sv
// Loadable address counter for the ROM reader.
//   clk, rst    : clock, synchronous active-high reset (clears to 0)
//   carga       : load valor_carga on the next edge (wins over incr)
//   incr        : advance by one, wrapping from 2^AW-1 back to 0
//   valor_carga : load value
//   cuenta      : registered count, drives the ROM address directly
module contador_dir
  import rom_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          carga,
  input  logic          incr,
  input  logic [AW-1:0] valor_carga,
  output logic [AW-1:0] cuenta
);

  logic [AW-1:0] cuenta_r;

  // Count register: reset, load, or wrap-around increment; otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      cuenta_r <= {AW{1'b0}};
    end else if (carga) begin
      cuenta_r <= valor_carga;
    end else if (incr) begin
      cuenta_r <= cuenta_r + AW'(1);  // truncation provides the modulo wrap
    end else begin
      cuenta_r <= cuenta_r;
    end
  end

  assign cuenta = cuenta_r;

endmodule

// File: rtl/rom_lector.sv
// Sequential block reader sitting in front of a small combinational ROM.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rom_lector_if master side (request, ROM port, output stream,
//              status)
// A start pulse loads the first address and word count; each word is fetched
// in one cycle and then held on dato_out until the consumer accepts it, so a
// word costs two cycles at best. fin pulses one cycle after the last accept.
module rom_lector
  import rom_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic clk,
  input  logic rst,
  rom_lector_if.master bus
);

  // Count of 0 on n_palabras requests the whole ROM.
  localparam logic [AW:0] PROF_L = {1'b1, {AW{1'b0}}};

  estado_t       state_r, state_s;
  logic [AW:0]   restante_r, restante_s;
  logic [DW-1:0] dato_out_r, dato_out_s;
  logic          valido_r, valido_s;
  logic          ocupado_r;
  logic          fin_r;
  logic          carga_s;
  logic          incr_s;

  contador_dir #(.AW(AW)) u_contador_dir (
    .clk         (clk),
    .rst         (rst),
    .carga       (carga_s),
    .incr        (incr_s),
    .valor_carga (bus.dir_inicial),
    .cuenta      (bus.address)
  );

  // Next-state logic, word capture and handshake bookkeeping.
  always_comb begin
    state_s    = state_r;
    restante_s = restante_r;
    dato_out_s = dato_out_r;
    valido_s   = valido_r;
    carga_s    = 1'b0;
    incr_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.inicio) begin
          carga_s    = 1'b1;
          restante_s = (bus.n_palabras == {(AW+1){1'b0}}) ? PROF_L : bus.n_palabras;
          state_s    = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        dato_out_s = bus.datos;
        valido_s   = 1'b1;
        state_s    = SEND;
      end
      SEND: begin
        if (valido_r && bus.listo) begin
          valido_s   = 1'b0;
          restante_s = restante_r - {{AW{1'b0}}, 1'b1};
          if (restante_r == {{AW{1'b0}}, 1'b1}) begin
            state_s = DONE;
          end else begin
            incr_s  = 1'b1;
            state_s = FETCH;
          end
        end else begin
          state_s = SEND;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; status flags are decoded from the next state
  // so they change on the same edge as the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      restante_r <= {(AW+1){1'b0}};
      dato_out_r <= {DW{1'b0}};
      valido_r   <= 1'b0;
      ocupado_r  <= 1'b0;
      fin_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      restante_r <= restante_s;
      dato_out_r <= dato_out_s;
      valido_r   <= valido_s;
      ocupado_r  <= (state_s != IDLE);
      fin_r      <= (state_s == DONE);
    end
  end

  assign bus.dato_out = dato_out_r;
  assign bus.valido   = valido_r;
  assign bus.ocupado  = ocupado_r;
  assign bus.fin      = fin_r;

endmodule

// File: tb/tb_rom_lector.sv
// Self-checking bench for rom_lector. The ROM is modelled as word k = F - k.
// Expected address/word sequences are built up front from the start address
// and count with modulo arithmetic, then consumed word by word.
module tb_rom_lector;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  rom_lector_if #(.AW(3), .DW(4)) bus ();

  rom_lector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.datos = 4'hF - {1'b0, bus.address};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Runs one block. stall < 0 means a random 0..3 cycle stall per word.
  // try_restart raises inicio with junk parameters in the middle of a stall.
  task automatic run_block(input logic [2:0] dir, input logic [3:0] n,
                           input int stall, input bit try_restart);
    int         cnt;
    int         ns;
    logic [2:0] a_q[$];
    logic [3:0] w_q[$];
    logic [2:0] ea;
    logic [3:0] ew;
    cnt = (n == 4'd0) ? 8 : int'(n);
    for (int k = 0; k < cnt; k++) begin
      a_q.push_back(3'((int'(dir) + k) % 8));
      w_q.push_back(4'(15 - ((int'(dir) + k) % 8)));
    end
    ea = dir;
    bus.dir_inicial = dir;
    bus.n_palabras  = n;
    bus.inicio      = 1'b1;
    @(posedge clk); #1;
    bus.inicio      = 1'b0;
    bus.dir_inicial = 3'($urandom);
    bus.n_palabras  = 4'($urandom);
    check_val("ocupado_start", 32'(bus.ocupado), 32'd1);
    while (a_q.size() > 0) begin
      ea = a_q.pop_front();
      ew = w_q.pop_front();
      check_val("fetch_valido", 32'(bus.valido), 32'd0);
      check_val("fetch_addr", 32'(bus.address), 32'(ea));
      bus.listo = 1'($urandom);
      @(posedge clk); #1;
      check_val("word_valido", 32'(bus.valido), 32'd1);
      check_val("word_data", 32'(bus.dato_out), 32'(ew));
      check_val("word_addr", 32'(bus.address), 32'(ea));
      ns = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int s = 0; s < ns; s++) begin
        bus.listo = 1'b0;
        if (try_restart && s == 1) begin
          bus.inicio      = 1'b1;
          bus.dir_inicial = 3'($urandom);
          bus.n_palabras  = 4'($urandom);
        end
        @(posedge clk); #1;
        bus.inicio = 1'b0;
        check_val("stall_valido", 32'(bus.valido), 32'd1);
        check_val("stall_data", 32'(bus.dato_out), 32'(ew));
        check_val("stall_addr", 32'(bus.address), 32'(ea));
        check_val("stall_fin", 32'(bus.fin), 32'd0);
        check_val("stall_ocupado", 32'(bus.ocupado), 32'd1);
      end
      bus.listo = 1'b1;
      @(posedge clk); #1;
      check_val("hs_valido", 32'(bus.valido), 32'd0);
      if (a_q.size() == 0) begin
        check_val("done_fin", 32'(bus.fin), 32'd1);
        check_val("done_ocupado", 32'(bus.ocupado), 32'd1);
        check_val("done_addr", 32'(bus.address), 32'(ea));
      end else begin
        check_val("mid_fin", 32'(bus.fin), 32'd0);
      end
    end
    bus.listo = 1'($urandom);
    @(posedge clk); #1;
    check_val("idle_fin", 32'(bus.fin), 32'd0);
    check_val("idle_ocupado", 32'(bus.ocupado), 32'd0);
    check_val("idle_valido", 32'(bus.valido), 32'd0);
    check_val("idle_addr", 32'(bus.address), 32'(ea));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    bus.inicio      = 1'b0;
    bus.dir_inicial = 3'd0;
    bus.n_palabras  = 4'd0;
    bus.listo       = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("rst_addr", 32'(bus.address), 32'd0);
    check_val("rst_dato", 32'(bus.dato_out), 32'd0);
    check_val("rst_valido", 32'(bus.valido), 32'd0);
    check_val("rst_ocupado", 32'(bus.ocupado), 32'd0);
    check_val("rst_fin", 32'(bus.fin), 32'd0);

    run_block(3'd2, 4'd3, 0, 1'b0);   // words D, C, B back to back
    run_block(3'd6, 4'd4, 0, 1'b0);   // wraps 7 -> 0
    run_block(3'd0, 4'd0, 0, 1'b0);   // count 0 = full ROM
    run_block(3'd3, 4'd5, 5, 1'b1);   // long stalls, ignored restart

    // Reset while a word is waiting for the consumer.
    bus.dir_inicial = 3'd1;
    bus.n_palabras  = 4'd4;
    bus.inicio      = 1'b1;
    @(posedge clk); #1;
    bus.inicio = 1'b0;
    bus.listo  = 1'b0;
    @(posedge clk); #1;
    check_val("pre_rst_valido", 32'(bus.valido), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("mid_rst_valido", 32'(bus.valido), 32'd0);
    check_val("mid_rst_ocupado", 32'(bus.ocupado), 32'd0);
    check_val("mid_rst_fin", 32'(bus.fin), 32'd0);
    check_val("mid_rst_addr", 32'(bus.address), 32'd0);
    check_val("mid_rst_dato", 32'(bus.dato_out), 32'd0);
    bus.listo = 1'b1;
    @(posedge clk); #1;
    check_val("post_rst_fin", 32'(bus.fin), 32'd0);
    check_val("post_rst_ocupado", 32'(bus.ocupado), 32'd0);
    run_block(3'd5, 4'd1, 0, 1'b0);   // single word A

    for (int i = 0; i < 12; i++) begin
      run_block(3'($urandom), 4'($urandom_range(0, 15)), -1, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
